// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg: widths, port ids and FSM state encoding shared by the psram_arbiter files.
package psram_arb_pkg;
    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;
    localparam logic PORT_DISP = 1'b0;
    localparam logic PORT_GEN = 1'b1;
    typedef enum logic [2:0] {
        ST_WAIT_GOOD = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;
endpackage

// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if: requester ports and psram_ctrlr application interface seen by the arbiter.
interface psram_arbiter_if;
    import psram_arb_pkg::*;
    logic              req0_valid, req1_valid, req0_we, req1_we;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_wdata, req1_wdata, req0_rdata, req1_rdata;
    logic              req0_grant, req1_grant, req0_done, req1_done, err_timeout;
    logic [ADDR_W-1:0] app_addr;
    logic [DATA_W-1:0] app_data_in, app_data_out;
    logic              app_wr, app_rd, app_burst_op;
    logic              app_ctrlr_good, app_op_begun, op_finished;
    modport master (
        output req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr, req0_wdata, req1_wdata,
        input  req0_grant, req1_grant, req0_done, req1_done, req0_rdata, req1_rdata, err_timeout,
        input  app_addr, app_data_in, app_wr, app_rd, app_burst_op,
        output app_ctrlr_good, app_op_begun, op_finished, app_data_out
    );
    modport slave (
        input  req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr, req0_wdata, req1_wdata,
        output req0_grant, req1_grant, req0_done, req1_done, req0_rdata, req1_rdata, err_timeout,
        output app_addr, app_data_in, app_wr, app_rd, app_burst_op,
        input  app_ctrlr_good, app_op_begun, op_finished, app_data_out
    );
endinterface

// File: rtl/arb_prio2.sv
// arb_prio2: fixed priority to port 0, overridden for port 1 once port 0 has starved it long enough.
module arb_prio2
    import psram_arb_pkg::*;
#(
    parameter int SW = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic          v0,
    input  logic          v1,
    input  logic [SW-1:0] starve_cnt,
    output logic          any,
    output logic          sel
);
    always_comb begin
        any = v0 | v1;
        sel = (v1 && (!v0 || starve_cnt >= SW'(STARVE_MAX))) ? PORT_GEN : PORT_DISP;
    end
endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: shares the psram_ctrlr application port between a display and a general requester,
// one single-word operation at a time, with starvation guard and hung-controller timeout.
module psram_arbiter
    import psram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input logic app_clk,
    input logic clr_n,
    psram_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1) < 3 ? 3 : $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state, nxt;
    logic [SW-1:0]     starve, starve_d;
    logic [TW-1:0]     tcnt, tcnt_d;
    logic              cmd_we, cmd_port, win_any, win_port, load, cap, strobe, strobe_d, timed_out;
    logic [1:0]        grant_d, done_d, grant_q, done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
    logic              wr_q, rd_q, err_q;

    arb_prio2 #(.SW(SW), .STARVE_MAX(STARVE_MAX)) u_prio (
        .v0(bus.req0_valid),
        .v1(bus.req1_valid),
        .starve_cnt(starve),
        .any(win_any),
        .sel(win_port)
    );

    assign strobe = wr_q | rd_q;

    always_ff @(posedge app_clk or negedge clr_n)
        if (!clr_n) state <= ST_WAIT_GOOD;
        else state <= nxt;

    always_comb begin
        nxt = state;
        grant_d = '0;
        done_d = '0;
        strobe_d = 1'b0;
        load = 1'b0;
        cap = 1'b0;
        timed_out = 1'b0;
        starve_d = starve;
        tcnt_d = tcnt;
        case (state)
            ST_WAIT_GOOD: nxt = bus.app_ctrlr_good ? ST_IDLE : ST_WAIT_GOOD;
            ST_IDLE:
                if (!bus.app_ctrlr_good) nxt = ST_WAIT_GOOD;
                else begin
                    starve_d = bus.req1_valid ? starve : '0;
                    if (win_any) begin
                        nxt = ST_ISSUE;
                        load = 1'b1;
                        grant_d[win_port] = 1'b1;
                        tcnt_d = '0;
                        starve_d = (win_port == PORT_GEN || !bus.req1_valid) ? '0 :
                                   (starve < SW'(STARVE_MAX)) ? starve + SW'(1) : starve;
                    end
                end
            ST_ISSUE: begin
                // op_begun only counts once our strobe is actually visible to the controller
                tcnt_d = tcnt + TW'(1);
                strobe_d = !(strobe && bus.app_op_begun);
                nxt = (strobe && bus.app_op_begun) ? ST_WAIT : ST_ISSUE;
            end
            ST_WAIT: begin
                tcnt_d = tcnt + TW'(1);
                if (bus.op_finished) begin
                    nxt = ST_DONE;
                    done_d[cmd_port] = 1'b1;
                    cap = !cmd_we;
                end
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_WAIT_GOOD;
        endcase
        if ((state == ST_ISSUE || state == ST_WAIT) && tcnt == TW'(TIMEOUT_CYCLES - 1) && nxt != ST_DONE) begin
            timed_out = 1'b1;
            nxt = ST_WAIT_GOOD;
            strobe_d = 1'b0;
            done_d = '0;
            done_d[cmd_port] = 1'b1;
        end
    end

    always_ff @(posedge app_clk or negedge clr_n)
        if (!clr_n) begin
            starve <= '0;
            tcnt <= '0;
            grant_q <= '0;
            done_q <= '0;
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            err_q <= 1'b0;
            cmd_we <= 1'b0;
            cmd_port <= PORT_DISP;
            addr_q <= '0;
            wdata_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            starve <= starve_d;
            tcnt <= tcnt_d;
            grant_q <= grant_d;
            done_q <= done_d;
            wr_q <= strobe_d && cmd_we;
            rd_q <= strobe_d && !cmd_we;
            err_q <= err_q | timed_out;
            if (load) begin
                cmd_port <= win_port;
                cmd_we <= win_port ? bus.req1_we : bus.req0_we;
                addr_q <= win_port ? bus.req1_addr : bus.req0_addr;
                wdata_q <= win_port ? bus.req1_wdata : bus.req0_wdata;
            end
            if (cap && cmd_port == PORT_DISP) rdata0_q <= bus.app_data_out;
            if (cap && cmd_port == PORT_GEN) rdata1_q <= bus.app_data_out;
        end

    assign bus.req0_grant = grant_q[0];
    assign bus.req1_grant = grant_q[1];
    assign bus.req0_done = done_q[0];
    assign bus.req1_done = done_q[1];
    assign bus.req0_rdata = rdata0_q;
    assign bus.req1_rdata = rdata1_q;
    assign bus.err_timeout = err_q;
    assign bus.app_addr = addr_q;
    assign bus.app_data_in = wdata_q;
    assign bus.app_wr = wr_q;
    assign bus.app_rd = rd_q;
    assign bus.app_burst_op = 1'b0;
endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: randomized requesters and a controller model; a scoreboard checks every done
// against a memory/arbitration reference built from the intended behaviour.
module tb_psram_arbiter;
    import psram_arb_pkg::*;

    typedef struct {
        logic        port;
        logic [15:0] rdata;
    } exp_t;

    logic app_clk = 1'b0;
    logic clr_n = 1'b0;
    psram_arbiter_if bus();
    psram_arbiter #(.STARVE_MAX(4), .TIMEOUT_CYCLES(1023)) dut (.app_clk(app_clk), .clr_n(clr_n), .bus(bus));
    always #5 app_clk = ~app_clk;

    int total = 0, bad = 0, cyc = 0;
    int run = 0, grant_cyc = 0, done_cyc = 0, good_cyc = 0, g = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_w, pv0 = 1'b0, pv1 = 1'b0;
    logic gseq[$];
    logic [15:0] ref_mem[logic [22:0]];
    logic [15:0] cm_mem[logic [22:0]];
    logic [15:0] last_rd[2];
    bit hang = 0, both_mode = 0, rand_dly = 0, cm_abort = 0, begun_c = 0;
    int cfg_b = 0, cfg_f = 1, ph = 0, cnt = 0;
    logic [22:0] seen_addr;
    logic [15:0] seen_data;
    logic seen_we;

    always @(posedge app_clk) cyc <= cyc + 1;

    function automatic logic [15:0] dflt(input logic [22:0] a);
        logic [15:0] t;
        t = a[15:0];
        return t ^ 16'hA5C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic issue(input logic p, input logic we, input logic [22:0] a, input logic [15:0] d);
        int n;
        exp_t e;
        n = 0;
        if (p) begin bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_valid = 1'b1; end
        else begin bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_valid = 1'b1; end
        do begin
            @(posedge app_clk); #1;
            n++;
        end while (!(p ? bus.req1_grant : bus.req0_grant) && n < 3000);
        check(p ? "grant_wait1" : "grant_wait0", 32'(n < 3000), 1);
        if (n < 3000) begin
            e.port = p;
            if (hang) e.rdata = last_rd[p];
            else if (we) begin
                ref_mem[a] = d;
                e.rdata = last_rd[p];
            end else begin
                e.rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
                last_rd[p] = e.rdata;
            end
            exp_q.push_back(e);
        end
        @(posedge app_clk); #1;
        // scramble request fields so a command register that re-reads them is exposed
        if (p) begin bus.req1_valid = 1'b0; bus.req1_addr = 23'($urandom); bus.req1_wdata = 16'($urandom); end
        else begin bus.req0_valid = 1'b0; bus.req0_addr = 23'($urandom); bus.req0_wdata = 16'($urandom); end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(posedge app_clk); #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    always @(negedge app_clk) begin
        if (clr_n) begin
            if (bus.req0_grant || bus.req1_grant) begin
                check("grant_onehot", 32'(bus.req0_grant && bus.req1_grant), 0);
                mon_w = pv1 && (!pv0 || run >= 4);
                check("grant_port", 32'(bus.req1_grant), 32'(mon_w));
                run = mon_w ? 0 : (pv1 ? run + 1 : 0);
                gseq.push_back(bus.req1_grant);
                grant_cyc = cyc;
            end
            if (bus.req0_done || bus.req1_done) begin
                done_cyc = cyc;
                check("done_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("done_port", 32'(bus.req1_done), 32'(mon_e.port));
                    check("done_onehot", 32'(bus.req0_done && bus.req1_done), 0);
                    check("rdata", mon_e.port ? bus.req1_rdata : bus.req0_rdata, 32'(mon_e.rdata));
                end
            end
        end
        pv0 = bus.req0_valid;
        pv1 = bus.req1_valid;
    end

    // controller model: begins cfg_b cycles after the strobe appears, finishes cfg_f cycles later
    initial begin
        bus.app_op_begun = 1'b0;
        bus.op_finished = 1'b0;
        bus.app_data_out = '0;
        forever begin
            @(posedge app_clk); #1;
            bus.app_op_begun = 1'b0;
            bus.op_finished = 1'b0;
            if (!clr_n || cm_abort) begin
                ph = 0;
                cm_abort = 0;
                begun_c = 0;
            end else begin
                if (ph == 0 && (bus.app_wr || bus.app_rd)) begin
                    seen_we = bus.app_wr;
                    seen_addr = bus.app_addr;
                    seen_data = bus.app_data_in;
                    if (rand_dly) begin
                        cfg_b = $urandom_range(0, 3);
                        cfg_f = $urandom_range(1, 4);
                        both_mode = ($urandom_range(0, 3) == 0);
                    end
                    cnt = cfg_b;
                    ph = 1;
                end
                if (ph == 1) begin
                    check("strobe_held", 32'(bus.app_wr || bus.app_rd), 1);
                    if (cnt == 0) begin
                        bus.app_op_begun = 1'b1;
                        bus.op_finished = both_mode;
                        bus.app_data_out = 16'hDEAD;
                        cnt = cfg_f;
                        begun_c = 1;
                        ph = 2;
                    end else cnt--;
                end else if (ph == 2) begin
                    if (begun_c) begin
                        check("strobe_drop", 32'(bus.app_wr || bus.app_rd), 0);
                        begun_c = 0;
                    end
                    cnt--;
                    if (cnt == 0 && !hang) begin
                        bus.op_finished = 1'b1;
                        if (seen_we) begin
                            cm_mem[seen_addr] = seen_data;
                            bus.app_data_out = 16'($urandom);
                        end else bus.app_data_out = cm_mem.exists(seen_addr) ? cm_mem[seen_addr] : dflt(seen_addr);
                        ph = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic exp_seq[$];
        int sc;
        bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_we = 0; bus.req1_we = 0;
        bus.req0_addr = 0; bus.req1_addr = 0; bus.req0_wdata = 0; bus.req1_wdata = 0;
        bus.app_ctrlr_good = 0;
        last_rd[0] = 0;
        last_rd[1] = 0;
        repeat (3) @(posedge app_clk);
        #1;
        check("rst_grant", {30'd0, bus.req1_grant, bus.req0_grant}, 0);
        check("rst_done", {30'd0, bus.req1_done, bus.req0_done}, 0);
        check("rst_strobe", {30'd0, bus.app_wr, bus.app_rd}, 0);
        check("rst_addr", 32'(bus.app_addr), 0);
        check("rst_data_in", 32'(bus.app_data_in), 0);
        check("rst_rdata", {bus.req1_rdata, bus.req0_rdata}, 0);
        check("rst_err", 32'(bus.err_timeout), 0);
        check("burst_tied", 32'(bus.app_burst_op), 0);
        clr_n = 1;

        // held in WAIT_GOOD while the controller is not good, IDLE one cycle after good
        fork
            issue(0, 0, 23'h20, 16'h0);
            begin
                repeat (10) @(posedge app_clk);
                #1;
                check("no_grant_not_good", gseq.size(), 0);
                bus.app_ctrlr_good = 1;
                good_cyc = cyc;
            end
        join
        check("idle_after_good", grant_cyc - good_cyc, 2);
        drain();

        cfg_b = 2; cfg_f = 4;
        issue(1, 1, 23'h1, 16'hBABE);
        drain();
        check("wr_seen_we", 32'(seen_we), 1);
        check("wr_seen_addr", 32'(seen_addr), 1);
        check("wr_seen_data", 32'(seen_data), 32'hBABE);
        check("data_in_held", 32'(bus.app_data_in), 32'hBABE);

        cm_mem[23'h10] = 16'h1234;
        ref_mem[23'h10] = 16'h1234;
        cfg_b = 1; cfg_f = 1;
        issue(0, 0, 23'h10, 16'h0);
        drain();
        check("rd_0x10", 32'(bus.req0_rdata), 32'h1234);
        issue(0, 1, 23'h11, 16'h5555);
        drain();
        check("rdata_held", 32'(bus.req0_rdata), 32'h1234);

        gseq.delete();
        fork
            repeat (8) issue(0, 0, 23'($urandom_range(0, 15)), 16'h0);
            repeat (2) issue(1, 0, 23'($urandom_range(0, 15)), 16'h0);
        join
        drain();
        sc = 0;
        for (int i = 0; i < 10; i++) begin
            exp_seq.push_back(sc == 4);
            sc = (sc == 4) ? 0 : sc + 1;
        end
        check("starve_count", gseq.size(), 10);
        for (int i = 0; i < 10 && i < gseq.size(); i++) check("starve_order", 32'(gseq[i]), 32'(exp_seq[i]));

        // controller never finishes: timeout, then recovery via WAIT_GOOD
        hang = 1;
        issue(1, 0, 23'h33, 16'h0);
        g = grant_cyc;
        fork
            issue(0, 1, 23'h40, 16'h7777);
            begin
                int n;
                n = 0;
                while (done_cyc <= g && n < 1100) begin
                    @(posedge app_clk); #1;
                    n++;
                end
                hang = 0;
                cm_abort = 1;
            end
        join
        check("timeout_latency", done_cyc - g, 1023);
        check("err_set", 32'(bus.err_timeout), 1);
        check("regrant_latency", grant_cyc - done_cyc, 2);
        drain();
        check("err_sticky", 32'(bus.err_timeout), 1);

        // reset in the middle of WAIT
        cfg_b = 0; cfg_f = 4;
        issue(0, 0, 23'h50, 16'h0);
        @(posedge app_clk); #1;
        clr_n = 0;
        #1;
        check("mid_rst_strobe", {30'd0, bus.app_wr, bus.app_rd}, 0);
        check("mid_rst_grant_done", {28'd0, bus.req1_grant, bus.req0_grant, bus.req1_done, bus.req0_done}, 0);
        check("mid_rst_addr", 32'(bus.app_addr), 0);
        check("mid_rst_data_in", 32'(bus.app_data_in), 0);
        check("mid_rst_rdata", {bus.req1_rdata, bus.req0_rdata}, 0);
        check("mid_rst_err", 32'(bus.err_timeout), 0);
        exp_q.delete();
        last_rd[0] = 0;
        last_rd[1] = 0;
        run = 0;
        repeat (3) @(posedge app_clk);
        #1;
        clr_n = 1;
        repeat (6) @(posedge app_clk);
        #1;
        issue(1, 0, 23'h50, 16'h0);
        drain();

        rand_dly = 1;
        fork
            repeat (30) begin
                repeat ($urandom_range(0, 3)) @(posedge app_clk);
                #1;
                issue(0, 1'($urandom_range(0, 1)), 23'($urandom_range(0, 15)), 16'($urandom));
            end
            repeat (30) begin
                repeat ($urandom_range(0, 3)) @(posedge app_clk);
                #1;
                issue(1, 1'($urandom_range(0, 1)), 23'($urandom_range(0, 15)), 16'($urandom));
            end
        join
        drain();
        repeat (5) @(posedge app_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
